// File: rtl/ttc_readout_scheduler.sv
// Serialises TTC trigger-FIFO events into readout requests for the command manager,
// pairing each non-empty event with one acquisition-complete pulse, in trigger order.
//
// state        | meaning
// IDLE         | ready to pop the next trigger word
// WAIT_ACQ     | non-empty event popped, waiting for an acquisition completion
// REQUEST      | readout_req held until readout_ack
// WAIT_READOUT | waiting for readout_done
// ERROR        | acquisition timeout; left only by reset
module ttc_readout_scheduler #(
    parameter logic [23:0] ACQ_TIMEOUT = 24'd4000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reset_trig_num,
    input  logic         fifo_valid,
    output logic         fifo_ready,
    input  logic [127:0] fifo_data,
    input  logic         acq_done,
    output logic         readout_req,
    input  logic         readout_ack,
    output logic         readout_empty,
    output logic [4:0]   readout_trig_type,
    output logic [23:0]  readout_event_num,
    output logic [23:0]  readout_trig_num,
    output logic [43:0]  readout_timestamp,
    input  logic         readout_done,
    output logic [4:0]   state,
    output logic [7:0]   acq_done_pending,
    output logic [31:0]  events_read,
    output logic [31:0]  empty_events,
    output logic         error_acq_timeout,
    output logic         error_seq,
    output logic         error_pending_ovf
);

    localparam logic [4:0] S_IDLE         = 5'b00001;
    localparam logic [4:0] S_WAIT_ACQ     = 5'b00010;
    localparam logic [4:0] S_REQUEST      = 5'b00100;
    localparam logic [4:0] S_WAIT_READOUT = 5'b01000;
    localparam logic [4:0] S_ERROR        = 5'b10000;

    logic [4:0]  state_nx;
    logic        pop;
    logic        pop_empty;
    logic [4:0]  pop_type;
    logic [23:0] pop_cnt;
    logic [23:0] pop_trig;
    logic [43:0] pop_ts;
    logic        consume;
    logic        timeout_hit;
    logic [23:0] acq_timer;
    logic [23:0] expected_event;
    logic        unused_fifo_hi;

    assign pop_empty      = fifo_data[97];
    assign pop_type       = fifo_data[96:92];
    assign pop_cnt        = fifo_data[91:68];
    assign pop_trig       = fifo_data[67:44];
    assign pop_ts         = fifo_data[43:0];
    assign unused_fifo_hi = ^fifo_data[127:98];

    assign pop         = fifo_valid & fifo_ready;
    assign consume     = (state == S_WAIT_ACQ) && ((acq_done_pending != 8'd0) || acq_done);
    assign timeout_hit = (ACQ_TIMEOUT != '0) && (acq_timer == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nx = pop_empty ? S_REQUEST : S_WAIT_ACQ;
                end
            end
            S_WAIT_ACQ: begin
                if (consume) begin
                    state_nx = S_REQUEST;
                end else if (timeout_hit) begin
                    state_nx = S_ERROR;
                end
            end
            S_REQUEST: begin
                if (readout_ack) begin
                    state_nx = S_WAIT_READOUT;
                end
            end
            S_WAIT_READOUT: begin
                if (readout_done) begin
                    state_nx = S_IDLE;
                end
            end
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs are gated by reset so they drop the instant reset rises.
    always_comb begin
        fifo_ready        = 1'b0;
        readout_req       = 1'b0;
        error_acq_timeout = (state == S_ERROR);
        if (!reset) begin
            fifo_ready  = (state == S_IDLE);
            readout_req = (state == S_REQUEST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readout_empty     <= 1'b0;
            readout_trig_type <= 5'd0;
            readout_event_num <= 24'd0;
            readout_trig_num  <= 24'd0;
            readout_timestamp <= 44'd0;
        end else if (pop) begin
            readout_empty     <= pop_empty;
            readout_trig_type <= pop_type;
            readout_event_num <= pop_cnt;
            readout_trig_num  <= pop_trig;
            readout_timestamp <= pop_ts;
        end
    end

    // Channel B reset wins over the expected-number update of a same-cycle pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected_event <= 24'd1;
            error_seq      <= 1'b0;
        end else begin
            if (pop && !pop_empty && (pop_cnt != expected_event)) begin
                error_seq <= 1'b1;
            end
            if (reset_trig_num) begin
                expected_event <= 24'd1;
            end else if (pop && !pop_empty) begin
                expected_event <= pop_cnt + 24'd1;
            end
        end
    end

    // Timeout down-counter reloads outside WAIT_ACQ, so it restarts on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acq_timer <= ACQ_TIMEOUT;
        end else if (state != S_WAIT_ACQ) begin
            acq_timer <= ACQ_TIMEOUT;
        end else if (acq_timer != '0) begin
            acq_timer <= acq_timer - 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acq_done_pending  <= 8'd0;
            error_pending_ovf <= 1'b0;
        end else if (acq_done && !consume) begin
            if (acq_done_pending == 8'hFF) begin
                error_pending_ovf <= 1'b1;
            end else begin
                acq_done_pending <= acq_done_pending + 8'd1;
            end
        end else if (consume && !acq_done) begin
            acq_done_pending <= acq_done_pending - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            events_read  <= 32'd0;
            empty_events <= 32'd0;
        end else begin
            if ((state == S_WAIT_READOUT) && readout_done) begin
                events_read <= events_read + 32'd1;
            end
            if ((state == S_REQUEST) && readout_ack && readout_empty) begin
                empty_events <= empty_events + 32'd1;
            end
        end
    end

endmodule

// File: doc/ttc_readout_scheduler.md
Name: ttc_readout_scheduler

Overview:
- Consumes the 128-bit trigger-info words written by the TTC trigger receiver into the TTC Trigger FIFO.
- Matches each accepted (non-empty) event with an acquisition-complete pulse from the channel acquisition controller, then issues one readout request per event to the command manager.
- Waits for the command manager's readout_done before taking the next FIFO word. Serialises readouts in trigger order.
- Sits between the TTC Trigger FIFO read side, the channel acquisition controller and the command manager, in the 40 MHz TTC clock domain.

Parameters:
ACQ_TIMEOUT, 24'd4000000, cycles to wait in WAIT_ACQ before a hard error (100 ms at 40 MHz); 0 disables the timeout.

Ports:
clk  input  1  40 MHz TTC clock
reset  input  1  asynchronous, active-high reset
reset_trig_num  input  1  TTC Channel B reset; restarts the expected event number at 1
fifo_valid  input  1  TTC Trigger FIFO has a word
fifo_ready  output  1  scheduler pops the word this cycle
fifo_data  input  128  {30'd0, empty[97], type[96:92], event_cnt[91:68], trig_num[67:44], timestamp[43:0]}
acq_done  input  1  one-cycle pulse: one event's acquisition has been stored in DDR3
readout_req  output  1  readout request to command manager
readout_ack  input  1  command manager accepts the request
readout_empty  output  1  latched empty flag
readout_trig_type  output  5  latched trigger type
readout_event_num  output  24  latched event count
readout_trig_num  output  24  latched trigger number
readout_timestamp  output  44  latched timestamp
readout_done  input  1  one-cycle pulse: readout finished
state  output  5  one-hot state
acq_done_pending  output  8  acquisitions completed but not yet scheduled
events_read  output  32  readouts completed, including empty events
empty_events  output  32  empty events scheduled
error_acq_timeout  output  1  sticky; high in ERROR
error_seq  output  1  sticky; event_cnt out of sequence
error_pending_ovf  output  1  sticky; acq_done at saturation

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, fifo_ready = 0, readout_req = 0.
  - All readout_* fields = 0.
  - All counters = 0, all error flags = 0, expected event = 1.
  - Asserting reset mid-operation drops readout_req immediately. No pending handshake is completed.
- fifo_ready is combinational: it equals state[IDLE]. A pop occurs when fifo_valid & fifo_ready. The data is latched into readout_* on that edge.
- IDLE:
  - On pop with empty = 1, go to REQUEST.
  - On pop with empty = 0, compare event_cnt to the expected event. On mismatch, set error_seq and continue. Set expected = event_cnt + 1 (24-bit wrap). Go to WAIT_ACQ.
  - With no pop, stay in IDLE.
- WAIT_ACQ:
  - The timeout counter clears on entry.
  - If acq_done_pending > 0 or acq_done = 1, consume one completion and go to REQUEST.
  - Else, if ACQ_TIMEOUT != 0 and the counter reaches ACQ_TIMEOUT, go to ERROR.
  - Otherwise increment the counter.
- REQUEST:
  - readout_req = 1 and is held until readout_ack. readout_* fields are stable throughout.
  - On readout_ack, go to WAIT_READOUT. readout_req falls the next cycle.
  - If this is an empty event, increment empty_events at the ack.
- WAIT_READOUT: on readout_done, increment events_read (32-bit wrap) and go to IDLE. The next pop is possible one cycle later.
- ERROR: absorbing, left only by reset. fifo_ready = 0, readout_req = 0, error_acq_timeout = 1.
- acq_done_pending, updated every cycle in all states except reset:
  - acq_done alone: +1.
  - Consume alone: −1.
  - acq_done and consume in the same cycle: unchanged.
  - acq_done at 255 with no consume: value stays at 255 and error_pending_ovf is set.
  - Consume is never issued at 0 unless acq_done is high in the same cycle.
- readout_done or readout_ack outside their states are ignored.
- reset_trig_num sets expected = 1 on the next edge. It takes priority over the update from a same-cycle pop.
- Empty events never consume acq_done and never check sequence.

Test Plan:
- Non-empty word (event_cnt = 1, type = 5'd1), then acq_done 10 cycles later:
  - readout_req rises 1 cycle after acq_done with readout_event_num = 1.
  - ack, then readout_done → events_read = 1, state = IDLE.
- acq_done pulses 3 times before any FIFO word, then 3 sequential non-empty words (event_cnt 1, 2, 3):
  - 3 readouts with no wait in WAIT_ACQ.
  - acq_done_pending goes 3 → 0.
  - error_seq = 0.
- Empty word (bit 97 = 1, type = 5'd2) with no acq_done: readout_req in the cycle after the pop; empty_events = 1; acq_done_pending unchanged.
- Words with event_cnt 1 then 3: error_seq set on the second pop; the second event is still read out.
- ACQ_TIMEOUT = 100, non-empty word and no acq_done:
  - ERROR after 100 cycles, error_acq_timeout = 1, fifo_ready stuck at 0.
  - reset returns the block to IDLE with all counters 0.
- acq_done asserted in the same cycle as the WAIT_ACQ consume while pending = 1: pending stays 1.
- 256 acq_done pulses with no words: pending = 255, error_pending_ovf = 1.
